// File: rtl/el2_pkg.sv
// Shared DCCM definitions: bank geometry helpers and the write-buffer entry type.
package el2_pkg;

  localparam int unsigned EL2_DCCM_BITS   = 16;
  localparam int unsigned EL2_NUM_BANKS   = 4;
  localparam int unsigned EL2_BYTE_WIDTH  = 4;
  localparam int unsigned EL2_FDATA_WIDTH = 39;

  function automatic int unsigned el2_bank_bits(input int unsigned nb);
    return (nb > 1) ? $clog2(nb) : 1;
  endfunction

  function automatic int unsigned el2_idx_bits(input int unsigned dccm_bits,
                                               input int unsigned nb,
                                               input int unsigned bw);
    return dccm_bits - el2_bank_bits(nb) - $clog2(bw);
  endfunction

  localparam int unsigned EL2_BANK_BITS = el2_bank_bits(EL2_NUM_BANKS);
  localparam int unsigned EL2_IDX_BITS  = el2_idx_bits(EL2_DCCM_BITS, EL2_NUM_BANKS, EL2_BYTE_WIDTH);

  typedef struct packed {
    logic                       unaligned;
    logic [EL2_BANK_BITS-1:0]   bank_lo;
    logic [EL2_BANK_BITS-1:0]   bank_hi;
    logic [EL2_IDX_BITS-1:0]    row_lo;
    logic [EL2_IDX_BITS-1:0]    row_hi;
    logic [EL2_FDATA_WIDTH-1:0] data_lo;
    logic [EL2_FDATA_WIDTH-1:0] data_hi;
  } el2_dccm_wb_entry_t;

endpackage

// File: rtl/el2_lsu_dccm_rdpipe.sv
// Read-return tracker: delays {valid, lo bank, hi bank} by RD_LAT cycles.
module el2_lsu_dccm_rdpipe #(
  parameter int unsigned RD_LAT    = 1,
  parameter int unsigned BANK_BITS = 2
) (
  input  logic                 i_clk,
  input  logic                 i_rst_l,
  input  logic                 i_valid,
  input  logic [BANK_BITS-1:0] i_bank_lo,
  input  logic [BANK_BITS-1:0] i_bank_hi,
  output logic                 o_valid,
  output logic [BANK_BITS-1:0] o_bank_lo,
  output logic [BANK_BITS-1:0] o_bank_hi
);

  logic [RD_LAT-1:0]    r_vld;
  logic [BANK_BITS-1:0] r_lo [RD_LAT];
  logic [BANK_BITS-1:0] r_hi [RD_LAT];

  // Shift the load tag one stage per cycle; reset drops anything in flight.
  always_ff @(posedge i_clk or negedge i_rst_l) begin
    if (!i_rst_l) begin
      r_vld <= '0;
      for (int unsigned s = 0; s < RD_LAT; s++) begin
        r_lo[s] <= '0;
        r_hi[s] <= '0;
      end
    end else begin
      r_vld[0] <= i_valid;
      r_lo[0]  <= i_bank_lo;
      r_hi[0]  <= i_bank_hi;
      for (int unsigned s = 1; s < RD_LAT; s++) begin
        r_vld[s] <= r_vld[s-1];
        r_lo[s]  <= r_lo[s-1];
        r_hi[s]  <= r_hi[s-1];
      end
    end
  end

  assign o_valid   = r_vld[RD_LAT-1];
  assign o_bank_lo = r_lo[RD_LAT-1];
  assign o_bank_hi = r_hi[RD_LAT-1];

endmodule

// File: rtl/el2_lsu_dccm_ctl_pipe.sv
// Banked DCCM front-end: load issue, store write buffer drained around loads,
// load/store hazard stall, store-starvation throttle and read-data return.
module el2_lsu_dccm_ctl_pipe
  import el2_pkg::*;
#(
  parameter int unsigned DCCM_BITS   = EL2_DCCM_BITS,
  parameter int unsigned NUM_BANKS   = EL2_NUM_BANKS,
  parameter int unsigned BYTE_WIDTH  = EL2_BYTE_WIDTH,
  parameter int unsigned FDATA_WIDTH = EL2_FDATA_WIDTH,
  parameter int unsigned RD_LAT      = 1,
  parameter int unsigned WB_DEPTH    = 2,
  parameter int unsigned STARVE_LIM  = 4
) (
  input  logic                                  clk,
  input  logic                                  rst_l,
  input  logic                                  clk_override,
  input  logic                                  wr_valid,
  output logic                                  wr_ready,
  input  logic [DCCM_BITS-1:0]                  wr_addr_lo,
  input  logic [DCCM_BITS-1:0]                  wr_addr_hi,
  input  logic [FDATA_WIDTH-1:0]                wr_data_lo,
  input  logic [FDATA_WIDTH-1:0]                wr_data_hi,
  input  logic                                  rd_valid,
  output logic                                  rd_ready,
  input  logic [DCCM_BITS-1:0]                  rd_addr_lo,
  input  logic [DCCM_BITS-1:0]                  rd_addr_hi,
  output logic                                  rd_data_valid,
  output logic [FDATA_WIDTH-1:0]                rd_data_lo,
  output logic [FDATA_WIDTH-1:0]                rd_data_hi,
  output logic                                  wb_empty,
  output logic [NUM_BANKS-1:0]                  bank_clken,
  output logic [NUM_BANKS-1:0]                  bank_wren,
  output logic [NUM_BANKS-1:0]                  bank_rden,
  output logic [NUM_BANKS*el2_idx_bits(DCCM_BITS, NUM_BANKS, BYTE_WIDTH)-1:0] bank_addr,
  output logic [NUM_BANKS*FDATA_WIDTH-1:0]      bank_wr_data,
  input  logic [NUM_BANKS*FDATA_WIDTH-1:0]      bank_dout
);

  localparam int unsigned BB  = el2_bank_bits(NUM_BANKS);
  localparam int unsigned OB  = $clog2(BYTE_WIDTH);
  localparam int unsigned IDX = el2_idx_bits(DCCM_BITS, NUM_BANKS, BYTE_WIDTH);
  localparam int unsigned FW  = FDATA_WIDTH;
  localparam int unsigned PW  = (WB_DEPTH > 1) ? $clog2(WB_DEPTH) : 1;
  localparam int unsigned CW  = $clog2(WB_DEPTH + 1);
  localparam int unsigned SW  = $clog2(STARVE_LIM + 1);

  // The buffer entry type is shared, so the bank geometry is pinned to it.
  if (DCCM_BITS != EL2_DCCM_BITS || NUM_BANKS != EL2_NUM_BANKS ||
      BYTE_WIDTH != EL2_BYTE_WIDTH || FDATA_WIDTH != EL2_FDATA_WIDTH) begin : g_geom_chk
    $error("el2_lsu_dccm_ctl_pipe: geometry must match el2_pkg entry type");
  end
  if (RD_LAT < 1 || RD_LAT > 3 || WB_DEPTH < 1 || WB_DEPTH > 4) begin : g_range_chk
    $error("el2_lsu_dccm_ctl_pipe: RD_LAT or WB_DEPTH out of range");
  end

  function automatic logic [NUM_BANKS-1:0] bank_sel(input logic [BB-1:0] b);
    bank_sel    = '0;
    bank_sel[b] = 1'b1;
  endfunction

  function automatic logic key_hit(input logic [BB+IDX-1:0] k,
                                   input logic [BB+IDX-1:0] ld_lo,
                                   input logic [BB+IDX-1:0] ld_hi,
                                   input logic              ld_unal);
    return (k == ld_lo) || (ld_unal && (k == ld_hi));
  endfunction

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(WB_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Address decode
  logic [BB-1:0]     w_wr_bank_lo, w_wr_bank_hi, w_rd_bank_lo, w_rd_bank_hi;
  logic [IDX-1:0]    w_wr_row_lo, w_wr_row_hi, w_rd_row_lo, w_rd_row_hi;
  logic              w_wr_unal, w_rd_unal;
  logic [BB+IDX-1:0] w_rd_key_lo, w_rd_key_hi;
  logic              w_unused_ofs;

  assign w_wr_bank_lo = wr_addr_lo[OB +: BB];
  assign w_wr_bank_hi = wr_addr_hi[OB +: BB];
  assign w_rd_bank_lo = rd_addr_lo[OB +: BB];
  assign w_rd_bank_hi = rd_addr_hi[OB +: BB];
  assign w_wr_row_lo  = wr_addr_lo[OB+BB +: IDX];
  assign w_wr_row_hi  = wr_addr_hi[OB+BB +: IDX];
  assign w_rd_row_lo  = rd_addr_lo[OB+BB +: IDX];
  assign w_rd_row_hi  = rd_addr_hi[OB+BB +: IDX];
  assign w_wr_unal    = (w_wr_bank_lo != w_wr_bank_hi);
  assign w_rd_unal    = (w_rd_bank_lo != w_rd_bank_hi);
  assign w_rd_key_lo  = {w_rd_bank_lo, w_rd_row_lo};
  assign w_rd_key_hi  = {w_rd_bank_hi, w_rd_row_hi};
  assign w_unused_ofs = ^{wr_addr_lo[OB-1:0], wr_addr_hi[OB-1:0],
                          rd_addr_lo[OB-1:0], rd_addr_hi[OB-1:0]};

  // Write buffer state
  el2_dccm_wb_entry_t r_wb [WB_DEPTH];
  el2_dccm_wb_entry_t w_wr_entry, w_head;
  logic [WB_DEPTH-1:0] r_vld;
  logic [PW-1:0]       r_head, r_tail;
  logic [CW-1:0]       r_count;
  logic [SW-1:0]       r_starve;

  logic                 w_enq, w_drain, w_head_vld, w_hazard, w_throttle, w_rd_accept;
  logic [NUM_BANKS-1:0] w_ld_mask, w_hd_mask;

  assign w_wr_entry = '{unaligned: w_wr_unal,
                        bank_lo:   w_wr_bank_lo,
                        bank_hi:   w_wr_bank_hi,
                        row_lo:    w_wr_row_lo,
                        row_hi:    w_wr_row_hi,
                        data_lo:   wr_data_lo,
                        data_hi:   wr_data_hi};

  assign w_head     = r_wb[r_head];
  assign w_head_vld = r_vld[r_head];
  assign wr_ready   = (r_count < CW'(WB_DEPTH));
  assign wb_empty   = (r_count == '0);
  assign w_enq      = wr_valid & wr_ready;

  // Stall a load that touches any bank/row still waiting in the buffer.
  always_comb begin
    w_hazard = 1'b0;
    for (int unsigned e = 0; e < WB_DEPTH; e++) begin
      if (r_vld[e]) begin
        if (key_hit({r_wb[e].bank_lo, r_wb[e].row_lo}, w_rd_key_lo, w_rd_key_hi, w_rd_unal))
          w_hazard = 1'b1;
        if (r_wb[e].unaligned &&
            key_hit({r_wb[e].bank_hi, r_wb[e].row_hi}, w_rd_key_lo, w_rd_key_hi, w_rd_unal))
          w_hazard = 1'b1;
      end
    end
  end

  assign w_throttle  = (r_starve == SW'(STARVE_LIM));
  assign rd_ready    = ~w_hazard & ~w_throttle;
  assign w_rd_accept = rd_valid & rd_ready;
  assign w_ld_mask   = w_rd_accept ?
                       (bank_sel(w_rd_bank_lo) | (w_rd_unal ? bank_sel(w_rd_bank_hi) : '0)) : '0;
  assign w_hd_mask   = bank_sel(w_head.bank_lo) | (w_head.unaligned ? bank_sel(w_head.bank_hi) : '0);
  assign w_drain     = w_head_vld & ~|(w_hd_mask & w_ld_mask);

  // Per-bank controls: load owns its banks, the buffer head uses the rest.
  always_comb begin
    bank_rden    = w_ld_mask;
    bank_wren    = w_drain ? w_hd_mask : '0;
    bank_addr    = '0;
    bank_wr_data = '0;
    for (int unsigned i = 0; i < NUM_BANKS; i++) begin
      if (w_ld_mask[i]) begin
        bank_addr[i*IDX +: IDX] = (BB'(i) == w_rd_bank_lo) ? w_rd_row_lo : w_rd_row_hi;
      end else if (bank_wren[i]) begin
        bank_addr[i*IDX +: IDX]  = (BB'(i) == w_head.bank_lo) ? w_head.row_lo  : w_head.row_hi;
        bank_wr_data[i*FW +: FW] = (BB'(i) == w_head.bank_lo) ? w_head.data_lo : w_head.data_hi;
      end
    end
    bank_clken = bank_wren | bank_rden | {NUM_BANKS{clk_override}};
  end

  // Buffer payload needs no reset; validity is tracked separately.
  always_ff @(posedge clk) begin
    if (w_enq) r_wb[r_tail] <= w_wr_entry;
  end

  // Buffer pointers, valid bits and occupancy.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      r_vld   <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_enq) begin
        r_vld[r_tail] <= 1'b1;
        r_tail        <= ptr_inc(r_tail);
      end
      if (w_drain) begin
        r_vld[r_head] <= 1'b0;
        r_head        <= ptr_inc(r_head);
      end
      r_count <= r_count + CW'(w_enq) - CW'(w_drain);
    end
  end

  // Count cycles the head is blocked; reaching the limit throttles loads for
  // one cycle, which guarantees the drain that clears the count again.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      r_starve <= '0;
    end else if (w_drain) begin
      r_starve <= '0;
    end else if (w_head_vld && !w_throttle) begin
      r_starve <= r_starve + 1'b1;
    end
  end

  // Read return path
  logic          w_pipe_vld;
  logic [BB-1:0] w_pipe_lo, w_pipe_hi;

  el2_lsu_dccm_rdpipe #(
    .RD_LAT    (RD_LAT),
    .BANK_BITS (BB)
  ) u_rdpipe (
    .i_clk     (clk),
    .i_rst_l   (rst_l),
    .i_valid   (w_rd_accept),
    .i_bank_lo (w_rd_bank_lo),
    .i_bank_hi (w_rd_unal ? w_rd_bank_hi : w_rd_bank_lo),
    .o_valid   (w_pipe_vld),
    .o_bank_lo (w_pipe_lo),
    .o_bank_hi (w_pipe_hi)
  );

  assign rd_data_valid = w_pipe_vld;

  // Select returning bank words by the delayed bank tags.
  always_comb begin
    rd_data_lo = '0;
    rd_data_hi = '0;
    for (int unsigned i = 0; i < NUM_BANKS; i++) begin
      if (w_pipe_lo == BB'(i)) rd_data_lo = bank_dout[i*FW +: FW];
      if (w_pipe_hi == BB'(i)) rd_data_hi = bank_dout[i*FW +: FW];
    end
  end

endmodule

// File: tb/tb_el2_lsu_dccm_ctl_pipe.sv
// Directed bench for el2_lsu_dccm_ctl_pipe with RD_LAT=2, WB_DEPTH=2.
module tb_el2_lsu_dccm_ctl_pipe;

  localparam int unsigned NB  = 4;
  localparam int unsigned FW  = 39;
  localparam int unsigned IDX = 12;

  logic              clk = 1'b0;
  logic              rst_l, clk_override;
  logic              wr_valid, wr_ready, rd_valid, rd_ready, rd_data_valid, wb_empty;
  logic [15:0]       wr_addr_lo, wr_addr_hi, rd_addr_lo, rd_addr_hi;
  logic [FW-1:0]     wr_data_lo, wr_data_hi, rd_data_lo, rd_data_hi;
  logic [NB-1:0]     bank_clken, bank_wren, bank_rden;
  logic [NB*IDX-1:0] bank_addr;
  logic [NB*FW-1:0]  bank_wr_data, bank_dout;

  always #5 clk = ~clk;

  el2_lsu_dccm_ctl_pipe #(
    .RD_LAT   (2),
    .WB_DEPTH (2)
  ) dut (
    .clk           (clk),
    .rst_l         (rst_l),
    .clk_override  (clk_override),
    .wr_valid      (wr_valid),
    .wr_ready      (wr_ready),
    .wr_addr_lo    (wr_addr_lo),
    .wr_addr_hi    (wr_addr_hi),
    .wr_data_lo    (wr_data_lo),
    .wr_data_hi    (wr_data_hi),
    .rd_valid      (rd_valid),
    .rd_ready      (rd_ready),
    .rd_addr_lo    (rd_addr_lo),
    .rd_addr_hi    (rd_addr_hi),
    .rd_data_valid (rd_data_valid),
    .rd_data_lo    (rd_data_lo),
    .rd_data_hi    (rd_data_hi),
    .wb_empty      (wb_empty),
    .bank_clken    (bank_clken),
    .bank_wren     (bank_wren),
    .bank_rden     (bank_rden),
    .bank_addr     (bank_addr),
    .bank_wr_data  (bank_wr_data),
    .bank_dout     (bank_dout)
  );

  // Bank RAM model, 2-cycle read latency
  logic [FW-1:0] mem [NB][4096];
  logic [FW-1:0] q1 [NB];
  logic [FW-1:0] q2 [NB];
  logic          ovr_en;
  logic [FW-1:0] ovr_val;

  always @(posedge clk) begin
    for (int b = 0; b < NB; b++) begin
      if (bank_wren[b]) mem[b][bank_addr[b*IDX +: IDX]] <= bank_wr_data[b*FW +: FW];
      if (bank_rden[b]) q1[b] <= mem[b][bank_addr[b*IDX +: IDX]];
      q2[b] <= q1[b];
    end
  end

  always_comb begin
    bank_dout = {q2[3], q2[2], q2[1], q2[0]};
    if (ovr_en) bank_dout[FW-1:0] = ovr_val;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic          rd_valid;
    logic          ovr;
    logic [15:0]   lo;
    logic [15:0]   hi;
    logic [NB-1:0] exp_rden;
    logic [NB-1:0] exp_clken;
    logic          exp_rdy;
    logic [47:0]   exp_addr;
  } vec_t;

  vec_t vecs [5];

  localparam logic [FW-1:0] D1 = 39'h11_2233_4455;
  localparam logic [FW-1:0] D2 = 39'h66_7788_99AA;
  localparam logic [FW-1:0] D3 = 39'h0A_BCDE_F012;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{1'b1, 1'b0, 16'h0010, 16'h0010, 4'b0001, 4'b0001, 1'b1, 48'h000000000001};
    vecs[1] = '{1'b1, 1'b0, 16'h0ABC, 16'h0AC0, 4'b1001, 4'b1001, 1'b1, 48'h0AB0000000AC};
    vecs[2] = '{1'b0, 1'b1, 16'h0010, 16'h0010, 4'b0000, 4'b1111, 1'b1, 48'h000000000000};
    vecs[3] = '{1'b1, 1'b0, 16'hFFF8, 16'hFFF8, 4'b0100, 4'b0100, 1'b1, 48'h000FFF000000};
    vecs[4] = '{1'b1, 1'b0, 16'h0004, 16'h0008, 4'b0110, 4'b0110, 1'b1, 48'h000000000000};

    rst_l = 1'b0; clk_override = 1'b0; wr_valid = 1'b0; rd_valid = 1'b0;
    wr_addr_lo = '0; wr_addr_hi = '0; wr_data_lo = '0; wr_data_hi = '0;
    rd_addr_lo = '0; rd_addr_hi = '0; ovr_en = 1'b0; ovr_val = '0;
    repeat (2) cyc();

    // Reset state
    chk("rst_wr_ready", 64'(wr_ready), 64'd1);
    chk("rst_wb_empty", 64'(wb_empty), 64'd1);
    chk("rst_rd_data_valid", 64'(rd_data_valid), 64'd0);
    chk("rst_bank_wren", 64'(bank_wren), 64'd0);
    chk("rst_bank_rden", 64'(bank_rden), 64'd0);
    chk("rst_rd_ready", 64'(rd_ready), 64'd1);
    rst_l = 1'b1;
    cyc();

    // Table: load decode and bank controls with an empty buffer
    for (int i = 0; i < 5; i++) begin
      rd_valid = vecs[i].rd_valid; clk_override = vecs[i].ovr;
      rd_addr_lo = vecs[i].lo; rd_addr_hi = vecs[i].hi;
      #1;
      chk($sformatf("vec%0d_rden", i), 64'(bank_rden), 64'(vecs[i].exp_rden));
      chk($sformatf("vec%0d_clken", i), 64'(bank_clken), 64'(vecs[i].exp_clken));
      chk($sformatf("vec%0d_rd_ready", i), 64'(rd_ready), 64'(vecs[i].exp_rdy));
      chk($sformatf("vec%0d_addr", i), 64'(bank_addr), 64'(vecs[i].exp_addr));
      cyc();
    end
    rd_valid = 1'b0; clk_override = 1'b0;
    repeat (3) cyc();

    // Aligned load, 2-cycle return
    ovr_en = 1'b1; ovr_val = 39'h5A;
    rd_valid = 1'b1; rd_addr_lo = 16'h0010; rd_addr_hi = 16'h0010;
    #1;
    chk("ld_rd_ready", 64'(rd_ready), 64'd1);
    chk("ld_rden", 64'(bank_rden), 64'b0001);
    cyc();
    rd_valid = 1'b0;
    #1 chk("ld_valid_lat1", 64'(rd_data_valid), 64'd0);
    cyc();
    #1;
    chk("ld_valid_lat2", 64'(rd_data_valid), 64'd1);
    chk("ld_data_lo", 64'(rd_data_lo), 64'h5A);
    chk("ld_data_hi", 64'(rd_data_hi), 64'h5A);
    cyc();
    #1 chk("ld_valid_lat3", 64'(rd_data_valid), 64'd0);
    ovr_en = 1'b0;
    cyc();

    // Unaligned store drains next cycle into banks 3 and 0
    wr_valid = 1'b1; wr_addr_lo = 16'h000C; wr_addr_hi = 16'h0010;
    wr_data_lo = D1; wr_data_hi = D2;
    #1;
    chk("st_wr_ready", 64'(wr_ready), 64'd1);
    chk("st_no_same_cycle_wren", 64'(bank_wren), 64'd0);
    cyc();
    wr_valid = 1'b0;
    #1;
    chk("st_wren", 64'(bank_wren), 64'b1001);
    chk("st_row_b3", 64'(bank_addr[47:36]), 64'd0);
    chk("st_row_b0", 64'(bank_addr[11:0]), 64'd1);
    chk("st_data_b3", 64'(bank_wr_data[3*FW +: FW]), 64'(D1));
    chk("st_data_b0", 64'(bank_wr_data[0 +: FW]), 64'(D2));
    chk("st_wb_busy", 64'(wb_empty), 64'd0);
    cyc();
    #1;
    chk("st_wb_empty", 64'(wb_empty), 64'd1);
    chk("st_wren_done", 64'(bank_wren), 64'd0);
    rd_valid = 1'b1; rd_addr_lo = 16'h000C; rd_addr_hi = 16'h0010;
    #1 chk("ua_rden", 64'(bank_rden), 64'b1001);
    cyc();
    rd_valid = 1'b0;
    cyc();
    #1;
    chk("ua_valid", 64'(rd_data_valid), 64'd1);
    chk("ua_data_lo", 64'(rd_data_lo), 64'(D1));
    chk("ua_data_hi", 64'(rd_data_hi), 64'(D2));
    cyc();

    // Load hitting a buffered store stalls until the store drains
    wr_valid = 1'b1; wr_addr_lo = 16'h0020; wr_addr_hi = 16'h0020;
    wr_data_lo = D3; wr_data_hi = D3;
    cyc();
    wr_valid = 1'b0;
    rd_valid = 1'b1; rd_addr_lo = 16'h0020; rd_addr_hi = 16'h0020;
    #1;
    chk("hz_rd_ready", 64'(rd_ready), 64'd0);
    chk("hz_wren", 64'(bank_wren), 64'b0001);
    chk("hz_rden", 64'(bank_rden), 64'd0);
    chk("hz_row", 64'(bank_addr[11:0]), 64'd2);
    cyc();
    #1;
    chk("hz_rd_ready_after", 64'(rd_ready), 64'd1);
    chk("hz_rden_after", 64'(bank_rden), 64'b0001);
    cyc();
    rd_valid = 1'b0;
    cyc();
    #1;
    chk("hz_valid", 64'(rd_data_valid), 64'd1);
    chk("hz_data", 64'(rd_data_lo), 64'(D3));
    repeat (3) cyc();

    // Back-to-back stores into a bank kept busy by loads: full, then starvation throttle
    rd_valid = 1'b1; rd_addr_lo = 16'h0004; rd_addr_hi = 16'h0004;
    wr_valid = 1'b1; wr_addr_lo = 16'h0054; wr_addr_hi = 16'h0054;
    wr_data_lo = 39'd1; wr_data_hi = 39'd1;
    #1;
    chk("sv_s0_wr_ready", 64'(wr_ready), 64'd1);
    cyc();
    wr_addr_lo = 16'h0064; wr_addr_hi = 16'h0064; wr_data_lo = 39'd2; wr_data_hi = 39'd2;
    #1;
    chk("sv_s1_wr_ready", 64'(wr_ready), 64'd1);
    chk("sv_s1_rd_ready", 64'(rd_ready), 64'd1);
    chk("sv_s1_wren", 64'(bank_wren), 64'd0);
    cyc();
    wr_addr_lo = 16'h0074; wr_addr_hi = 16'h0074; wr_data_lo = 39'd3; wr_data_hi = 39'd3;
    #1 chk("sv_s2_wr_full", 64'(wr_ready), 64'd0);
    cyc();
    wr_valid = 1'b0;
    #1 chk("sv_s3_rd_ready", 64'(rd_ready), 64'd1);
    cyc();
    #1;
    chk("sv_s4_rd_ready", 64'(rd_ready), 64'd1);
    chk("sv_s4_wren", 64'(bank_wren), 64'd0);
    cyc();
    #1;
    chk("sv_s5_throttle", 64'(rd_ready), 64'd0);
    chk("sv_s5_wren", 64'(bank_wren), 64'b0010);
    chk("sv_s5_row", 64'(bank_addr[23:12]), 64'd5);
    chk("sv_s5_rden", 64'(bank_rden), 64'd0);
    cyc();
    #1;
    chk("sv_s6_rd_ready", 64'(rd_ready), 64'd1);
    chk("sv_s6_wren", 64'(bank_wren), 64'd0);
    cyc();
    rd_valid = 1'b0;
    #1;
    chk("sv_s7_wren", 64'(bank_wren), 64'b0010);
    chk("sv_s7_row", 64'(bank_addr[23:12]), 64'd6);
    cyc();
    #1 chk("sv_s8_wb_empty", 64'(wb_empty), 64'd1);
    repeat (4) cyc();

    // Reset with two buffered stores and loads in flight
    rd_valid = 1'b1; rd_addr_lo = 16'h0004; rd_addr_hi = 16'h0004;
    wr_valid = 1'b1; wr_addr_lo = 16'h0054; wr_addr_hi = 16'h0054;
    cyc();
    wr_addr_lo = 16'h0064; wr_addr_hi = 16'h0064;
    #1 chk("mr_wb_busy", 64'(wb_empty), 64'd0);
    cyc();
    rd_valid = 1'b0; wr_valid = 1'b0; rst_l = 1'b0;
    #1;
    chk("mr_wb_empty", 64'(wb_empty), 64'd1);
    chk("mr_wr_ready", 64'(wr_ready), 64'd1);
    chk("mr_rd_data_valid", 64'(rd_data_valid), 64'd0);
    chk("mr_wren", 64'(bank_wren), 64'd0);
    cyc();
    rst_l = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      chk($sformatf("mr_post%0d_valid", c), 64'(rd_data_valid), 64'd0);
      chk($sformatf("mr_post%0d_wren", c), 64'(bank_wren), 64'd0);
      chk($sformatf("mr_post%0d_wb_empty", c), 64'(wb_empty), 64'd1);
      cyc();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
